vshs_gen: RTL and testbench

- Output-side video timing generator for the pixel path.
- Produces vs/hs/de/data with polarity selectable per frame.
- Counterpart of the input polarity normaliser: it re-applies polarity toward the panel or HDMI encoder.
- Pulls pixels from an upstream buffer through a fixed-latency request interface.

---
 rtl/vshs_gen.sv | 191 +++++++++++++++++++
 tb/tb_vshs_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vshs_gen.sv
`default_nettype none
// vshs_gen: output-side video timing generator with per-frame sync polarity and a
// three-stage pixel fetch pipeline toward an upstream buffer.  Rev 1.0
module vshs_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        vd_2fp_clk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic [1:0]  vhs_pol,
  input  logic [23:0] src_data,
  output logic        data_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic        busy,
  output logic        out_vs,
  output logic        out_hs,
  output logic        out_de,
  output logic [23:0] out_data
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [1:0]  pol_lat;

  logic        run;
  logic        frame_end;
  logic        frame_go;
  logic        hs_raw;
  logic        vs_raw;
  logic        act;
  logic        fs_raw;

  logic        s1_hs;
  logic        s1_vs;
  logic        s1_fs;
  logic [1:0]  s1_pol;
  logic        s2_hs;
  logic        s2_vs;
  logic        s2_fs;
  logic        s2_de;
  logic [1:0]  s2_pol;

  assign run       = (state == ST_RUN);
  assign busy      = run;
  assign frame_end = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // frame_go marks the edge at which the counters enter (0,0) for a new frame
  always_comb begin
    state_nxt = state;
    frame_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gen_en) begin
          state_nxt = ST_RUN;
          frame_go  = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (gen_en) begin
            frame_go = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_lat <= 2'b00;
    end else if (frame_go) begin
      pol_lat <= vhs_pol;
    end
  end

  assign hs_raw = run && (h_cnt < H_SYNC_END);
  assign vs_raw = run && (v_cnt < V_SYNC_END);
  assign act    = run && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                      && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign fs_raw = run && (h_cnt == 12'd0) && (v_cnt == 12'd0);

  // Syncs travel active-high with their frame's polarity so a mid-pipeline
  // polarity switch never touches the tail of the previous frame.
  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_req <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_fs    <= 1'b0;
      s1_pol   <= 2'b00;
    end else begin
      data_req <= act;
      pix_x    <= act ? (h_cnt - H_ACT_BEG) : 12'd0;
      pix_y    <= act ? (v_cnt - V_ACT_BEG) : 12'd0;
      s1_hs    <= hs_raw;
      s1_vs    <= vs_raw;
      s1_fs    <= fs_raw;
      s1_pol   <= pol_lat;
    end
  end

  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_fs  <= 1'b0;
      s2_de  <= 1'b0;
      s2_pol <= 2'b00;
    end else begin
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_fs  <= s1_fs;
      s2_de  <= data_req;
      s2_pol <= s1_pol;
    end
  end

  always_ff @(posedge vd_2fp_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hs      <= 1'b0;
      out_vs      <= 1'b0;
      out_de      <= 1'b0;
      frame_start <= 1'b0;
      out_data    <= '0;
    end else begin
      out_hs      <= s2_hs ~^ s2_pol[0];
      out_vs      <= s2_vs ~^ s2_pol[1];
      out_de      <= s2_de;
      frame_start <= s2_fs;
      out_data    <= s2_de ? src_data : 24'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vshs_gen.sv
`default_nettype none
// tb_vshs_gen: randomized scoreboard bench for vshs_gen against a frame-position model.
// Rev 1.0
module tb_vshs_gen;

  localparam int H_ACTIVE = 4;
  localparam int H_FP     = 1;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 3;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic [1:0]  vhs_pol = 2'b11;
  logic [23:0] src_data = 24'd0;
  logic        data_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_start;
  logic        busy;
  logic        out_vs;
  logic        out_hs;
  logic        out_de;
  logic [23:0] out_data;

  always #5 clk = ~clk;

  vshs_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .vd_2fp_clk (clk),
    .rst_n      (rst_n),
    .gen_en     (gen_en),
    .vhs_pol    (vhs_pol),
    .src_data   (src_data),
    .data_req   (data_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .busy       (busy),
    .out_vs     (out_vs),
    .out_hs     (out_hs),
    .out_de     (out_de),
    .out_data   (out_data)
  );

  typedef struct {
    bit        run;
    bit        hs;
    bit        vs;
    bit        act;
    bit        fs;
    bit [11:0] x;
    bit [11:0] y;
    bit [1:0]  pol;
  } slot_t;

  typedef struct {
    bit        busy;
    bit        req;
    bit        hs;
    bit        vs;
    bit        de;
    bit        fs;
    bit [11:0] px;
    bit [11:0] py;
    bit [23:0] data;
  } exp_t;

  slot_t tl[$];
  exp_t  sb[$];
  int    m_pos = -1;
  bit [1:0] m_pol = 2'b00;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Ideal frame timeline: position within the frame -> what the raw timing should be
  function automatic slot_t slot_of(input int pos, input bit [1:0] pol);
    slot_t s = '{default: '0};
    int col, line;
    s.pol = pol;
    if (pos >= 0) begin
      col    = pos % HT;
      line   = pos / HT;
      s.run  = 1'b1;
      s.hs   = (col < H_SYNC);
      s.vs   = (line < V_SYNC);
      s.act  = (col >= H_SYNC + H_BP) && (col < H_SYNC + H_BP + H_ACTIVE) &&
               (line >= V_SYNC + V_BP) && (line < V_SYNC + V_BP + V_ACTIVE);
      s.fs   = (pos == 0);
      if (s.act) begin
        s.x = 12'(col - H_SYNC - H_BP);
        s.y = 12'(line - V_SYNC - V_BP);
      end
    end
    return s;
  endfunction

  // Reference model: one expectation per clock; outputs lag the timeline by 1 (request) or 3 (video)
  initial begin
    exp_t e;
    slot_t d1, d3;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pos = -1;
        m_pol = 2'b00;
        tl.delete();
        repeat (4) tl.push_back(slot_of(-1, 2'b00));
        e = '{default: '0};
        sb.push_back(e);
      end else begin
        if (m_pos < 0) begin
          if (gen_en) begin m_pos = 0; m_pol = vhs_pol; end
        end else if (m_pos == FT - 1) begin
          if (gen_en) begin m_pos = 0; m_pol = vhs_pol; end
          else m_pos = -1;
        end else begin
          m_pos++;
        end
        tl.push_back(slot_of(m_pos, m_pol));
        void'(tl.pop_front());
        d1     = tl[2];
        d3     = tl[0];
        e.busy = tl[3].run;
        e.req  = d1.act;
        e.px   = d1.x;
        e.py   = d1.y;
        e.hs   = d3.hs ~^ d3.pol[0];
        e.vs   = d3.vs ~^ d3.pol[1];
        e.de   = d3.act;
        e.fs   = d3.fs;
        e.data = d3.act ? {d3.y, d3.x} : 24'd0;
        sb.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("busy",        32'(busy),           32'(e.busy));
        check("data_req",    32'(data_req),       32'(e.req));
        check("pix_xy",      32'({pix_y, pix_x}), 32'({e.py, e.px}));
        check("vs_hs",       32'({out_vs, out_hs}), 32'({e.vs, e.hs}));
        check("de",          32'(out_de),         32'(e.de));
        check("frame_start", 32'(frame_start),    32'(e.fs));
        check("out_data",    32'(out_data),       32'(e.data));
      end
    end
  end

  // Source buffer: answers a request one cycle later, garbage otherwise
  initial begin
    logic        req_s;
    logic [23:0] pix_s;
    forever begin
      @(negedge clk);
      req_s = data_req;
      pix_s = {pix_y, pix_x};
      @(posedge clk);
      #1;
      src_data = req_s ? pix_s : 24'($urandom);
    end
  end

  task automatic wait_pos(input int lo, input int hi);
    bit found = 1'b0;
    for (int k = 0; k < 4 * FT && !found; k++) begin
      @(negedge clk);
      if (m_pos >= lo && m_pos <= hi) found = 1'b1;
    end
    check("wait_pos", 32'(found), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    gen_en = 1'b1;
    repeat (2 * FT + 5) @(negedge clk);

    vhs_pol = 2'b00;
    repeat (FT + 20) @(negedge clk);

    wait_pos(2 * HT, 3 * HT - 1);
    gen_en = 1'b0;
    repeat (FT + 10) @(negedge clk);

    vhs_pol = 2'b11;
    gen_en  = 1'b1;
    wait_pos(2 * HT + 6, 2 * HT + 6);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {3'd0, data_req, pix_x, frame_start, busy, out_vs, out_hs, out_de},
          32'd0);
    check("async_reset_pix", {8'd0, pix_y, out_data[11:0]} | 32'(out_data), 32'd0);
    gen_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) gen_en = ~gen_en;
      if ($urandom_range(0, 29) == 0) vhs_pol = 2'($urandom);
    end
    gen_en = 1'b0;
    repeat (FT + 10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
